somador_subtrator_serial: RTL and testbench
===========================================

# somador_subtrator_serial

Parametrised, multi-cycle adder/subtractor for the datapath. It processes a WIDTH-bit operation CHUNK bits per clock, with the carry chained between slices through a register. It produces the sum/difference plus carry, signed-overflow, zero and negative flags. A valid/ready handshake on both sides lets the control unit and ALU stall it or be stalled by it. It replaces the single-cycle 16-bit add/sub wherever wider operands or a shorter critical path are needed.

## Interface
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits processed per cycle; WIDTH % CHUNK must be 0 (elaboration error otherwise); N = WIDTH/CHUNK.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; = (state==IDLE) & ~rst.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0: a+b, 1: a−b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- Cout  out  1  add: carry-out; sub: inverted borrow (1 when a ≥ b unsigned).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH-1].

## Operation
- States: IDLE, CALC, DONE.
- IDLE: when in_valid & in_ready, register a, b⊕{WIDTH{sub}}, sub. Preset the chunk index to 0 and the carry register to sub. Go to CALC.
- CALC: each cycle, add slice[idx] of a and b', plus the carry register. Write CHUNK result bits into s[idx], update the carry register, and increment idx. After slice N−1, go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE. No accept in the same cycle as the result handshake.
- Flag computation on entering DONE:
  - Cout = final carry.
  - ovf = (a[MSB]==b'[MSB]) & (s[MSB]!=a[MSB]).
  - zero = ~|s.
  - neg = s[MSB].
- Operand inputs are ignored outside the accept cycle; changes during CALC/DONE have no effect.
- s and the flags hold stable throughout DONE, including under backpressure.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset (any state, including mid-CALC): on the next edge, state=IDLE, idx=0, and s, Cout, ovf, zero, neg, out_valid all 0. The in-flight operation is discarded. in_ready is 0 while rst is high and 1 in the first cycle after.
- Latency: the accept edge E0 loads operands. Edges E1..EN compute slices. out_valid is high from EN until the out_ready handshake edge.
- Throughput: one operation per N+2 cycles with out_ready held high.
- N=1 (CHUNK==WIDTH): a single CALC cycle; out_valid 1 cycle after accept.
- out_valid never drops without out_ready. in_ready is 0 in CALC and DONE.

## Structure
- Shared package somador_pkg:
  - state enum (IDLE, CALC, DONE), 2-bit encoding.
  - function/constant for the N computation and the idx width ($clog2(N), minimum 1).
- Sub-module soma_fatia: combinational CHUNK-bit adder with cin, producing sum and cout. It is instantiated once and muxed by idx.
- Remaining logic lives in the top: FSM, operand registers, carry register, result register, flag logic.

## Test plan
All cases use WIDTH=32, CHUNK=8 unless stated.
- Add carry across slices: add 0x000000FF + 0x00000001 → s=0x00000100, Cout=0, ovf=0, zero=0. out_valid exactly 4 cycles after the accept edge.
- Subtract with and without borrow:
  - sub 5 − 7 → s=0xFFFFFFFE, Cout=0, neg=1, ovf=0.
  - sub 7 − 5 → s=2, Cout=1.
- Overflow and carry edges:
  - 0x7FFFFFFF + 1 → 0x80000000, ovf=1, neg=1, Cout=0.
  - 0xFFFFFFFF + 1 → 0, Cout=1, zero=1, ovf=0.
  - 0x80000000 − 1 → 0x7FFFFFFF, ovf=1.
- Backpressure and input isolation:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid, s and flags stable, in_ready=0.
  - Toggling a/b/sub during CALC does not change the result.
- Reset mid-operation: assert rst in the 2nd CALC cycle → next cycle out_valid=0, s=0, flags 0, and in_ready=1 after rst drops. A following 3+4 → 7.
- Degenerate instance WIDTH=CHUNK=16: 0x1234 − 0x1234 → s=0, Cout=1, zero=1. Latency 1 cycle.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM states and
// helpers that derive the slice count and slice-index width from the parameters.
package somador_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_n(input int width, input int chunk);
      return width / chunk;
   endfunction

   // A one-slice instance still needs a 1-bit index register.
   function automatic int calc_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/somador_subtrator_serial_soma_fatia.sv
// Combinational CHUNK-bit ripple slice: sum and carry-out of a + b + cin.
module soma_fatia #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign sum   = total[CHUNK-1:0];
   assign cout  = total[CHUNK];

endmodule

// File: rtl/somador_subtrator_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock through a
// single shared slice adder, carry held in a register, valid/ready on both sides.
module somador_subtrator_serial
   import somador_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             Cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int N   = calc_n(WIDTH, CHUNK);
   localparam int IW  = calc_idx_w(N);
   localparam int MSB = WIDTH - 1;

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("somador_subtrator_serial: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_t           state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] s_reg;
   logic [WIDTH-1:0] s_next;
   logic [IW-1:0]    idx_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic             zero_reg;
   logic             neg_reg;
   logic             out_valid_reg;

   logic [CHUNK-1:0] a_cur;
   logic [CHUNK-1:0] b_cur;
   logic [CHUNK-1:0] sum_cur;
   logic             cout_cur;
   logic             last_slice;

   // Select the operand slice addressed by idx; a single slice needs no mux.
   generate
      if (N == 1) begin : g_one_slice
         assign a_cur = a_reg;
         assign b_cur = b_reg;
      end else begin : g_multi_slice
         logic [CHUNK-1:0] a_sl [N];
         logic [CHUNK-1:0] b_sl [N];
         for (genvar gi = 0; gi < N; gi++) begin : g_sl
            assign a_sl[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_sl[gi] = b_reg[gi*CHUNK +: CHUNK];
         end
         assign a_cur = a_sl[idx_reg];
         assign b_cur = b_sl[idx_reg];
      end
   endgenerate

   soma_fatia #(
      .CHUNK (CHUNK)
   ) u_fatia (
      .a    (a_cur),
      .b    (b_cur),
      .cin  (carry_reg),
      .sum  (sum_cur),
      .cout (cout_cur)
   );

   // Result with the current slice merged in, so flags see the complete value.
   always_comb begin
      s_next = s_reg;
      for (int i = 0; i < N; i++) begin
         if (idx_reg == IW'(i)) begin
            s_next[i*CHUNK +: CHUNK] = sum_cur;
         end
      end
   end

   assign last_slice = (idx_reg == IW'(N - 1));
   assign in_ready   = (state_reg == IDLE) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         s_reg         <= '0;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         cout_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         zero_reg      <= 1'b0;
         neg_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1: invert b here, the +1 is the preset carry.
                  a_reg     <= a;
                  b_reg     <= b ^ {WIDTH{sub}};
                  carry_reg <= sub;
                  idx_reg   <= '0;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               s_reg     <= s_next;
               carry_reg <= cout_cur;
               idx_reg   <= idx_reg + IW'(1);
               if (last_slice) begin
                  idx_reg       <= '0;
                  cout_reg      <= cout_cur;
                  ovf_reg       <= (a_reg[MSB] == b_reg[MSB]) & (s_next[MSB] != a_reg[MSB]);
                  zero_reg      <= ~|s_next;
                  neg_reg       <= s_next[MSB];
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign s         = s_reg;
   assign Cout      = cout_reg;
   assign ovf       = ovf_reg;
   assign zero      = zero_reg;
   assign neg       = neg_reg;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Directed bench for the serial adder/subtractor: 32/8 main instance plus a 16/16 single-slice instance.
module tb_somador_subtrator_serial;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic        Cout;
   logic        ovf;
   logic        zero;
   logic        neg;

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        sub16;
   logic        out_valid16;
   logic        out_ready16;
   logic [15:0] s16;
   logic        cout16;
   logic        ovf16;
   logic        zero16;
   logic        neg16;

   int tests;
   int fails;
   int lat;

   somador_subtrator_serial #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .Cout(Cout), .ovf(ovf), .zero(zero), .neg(neg)
   );

   somador_subtrator_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
      .s(s16), .Cout(cout16), .ovf(ovf16), .zero(zero16), .neg(neg16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation on the 32-bit instance; returns edges from accept to out_valid.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input bit toggle, output int cycles);
      chk("in_ready before accept", {31'b0, in_ready}, 32'd1);
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         if (toggle) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            chk("in_ready low in CALC", {31'b0, in_ready}, 32'd0);
         end
         @(posedge clk);
         #1 cycles++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("out_valid cleared after handshake", {31'b0, out_valid}, 32'd0);
      chk("in_ready after handshake", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; out_ready16 = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk);
      #1;
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset s", s, 32'd0);
      chk("reset Cout", {31'b0, Cout}, 32'd0);
      chk("reset in_ready during rst", {31'b0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("in_ready after rst", {31'b0, in_ready}, 32'd1);

      // 0xFF + 1: carry ripples from slice 0 into slice 1
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
      chk("add ff+1 latency", lat, 32'd4);
      chk("add ff+1 s", s, 32'h0000_0100);
      chk("add ff+1 Cout", {31'b0, Cout}, 32'd0);
      chk("add ff+1 ovf", {31'b0, ovf}, 32'd0);
      chk("add ff+1 zero", {31'b0, zero}, 32'd0);
      release_result();

      // 5 - 7: borrow
      run_op(32'd5, 32'd7, 1'b1, 1'b0, lat);
      chk("sub 5-7 s", s, 32'hFFFF_FFFE);
      chk("sub 5-7 Cout", {31'b0, Cout}, 32'd0);
      chk("sub 5-7 neg", {31'b0, neg}, 32'd1);
      chk("sub 5-7 ovf", {31'b0, ovf}, 32'd0);
      release_result();

      // 7 - 5: no borrow
      run_op(32'd7, 32'd5, 1'b1, 1'b0, lat);
      chk("sub 7-5 s", s, 32'd2);
      chk("sub 7-5 Cout", {31'b0, Cout}, 32'd1);
      chk("sub 7-5 neg", {31'b0, neg}, 32'd0);
      release_result();

      // 0x7FFFFFFF + 1: positive overflow
      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
      chk("add max+1 s", s, 32'h8000_0000);
      chk("add max+1 ovf", {31'b0, ovf}, 32'd1);
      chk("add max+1 neg", {31'b0, neg}, 32'd1);
      chk("add max+1 Cout", {31'b0, Cout}, 32'd0);
      release_result();

      // 0xFFFFFFFF + 1: wraps to zero with carry
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
      chk("add ffff+1 s", s, 32'd0);
      chk("add ffff+1 Cout", {31'b0, Cout}, 32'd1);
      chk("add ffff+1 zero", {31'b0, zero}, 32'd1);
      chk("add ffff+1 ovf", {31'b0, ovf}, 32'd0);
      release_result();

      // 0x80000000 - 1: negative overflow
      run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, lat);
      chk("sub min-1 s", s, 32'h7FFF_FFFF);
      chk("sub min-1 ovf", {31'b0, ovf}, 32'd1);
      chk("sub min-1 Cout", {31'b0, Cout}, 32'd1);
      chk("sub min-1 neg", {31'b0, neg}, 32'd0);
      release_result();

      // Backpressure: result and flags hold for 10 cycles without out_ready
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("stall out_valid", {31'b0, out_valid}, 32'd1);
         chk("stall s", s, 32'h2345_6789);
         chk("stall in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall flags", {28'b0, Cout, ovf, zero, neg}, 32'd0);
      end
      release_result();

      // Operand changes during CALC are ignored
      run_op(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b1, lat);
      chk("toggle latency", lat, 32'd4);
      chk("toggle s", s, 32'h0000_1234);
      release_result();

      // Reset in the 2nd CALC cycle discards the operation
      a = 32'h0101_0101; b = 32'h0202_0202; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst s", s, 32'd0);
      chk("midrst flags", {28'b0, Cout, ovf, zero, neg}, 32'd0);
      chk("midrst in_ready during rst", {31'b0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst in_ready after rst", {31'b0, in_ready}, 32'd1);
      run_op(32'd3, 32'd4, 1'b0, 1'b0, lat);
      chk("after rst latency", lat, 32'd4);
      chk("after rst 3+4", s, 32'd7);
      release_result();

      // Single-slice instance: 0x1234 - 0x1234
      chk("w16 in_ready", {31'b0, in_ready16}, 32'd1);
      a16 = 16'h1234; b16 = 16'h1234; sub16 = 1'b1; in_valid16 = 1'b1;
      @(posedge clk);
      #1 in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("w16 latency", lat, 32'd1);
      chk("w16 s", {16'b0, s16}, 32'd0);
      chk("w16 Cout", {31'b0, cout16}, 32'd1);
      chk("w16 zero", {31'b0, zero16}, 32'd1);
      chk("w16 ovf", {31'b0, ovf16}, 32'd0);
      out_ready16 = 1'b1;
      @(posedge clk);
      #1 out_ready16 = 1'b0;
      chk("w16 out_valid cleared", {31'b0, out_valid16}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
